// File: rtl/riscv_defs.sv
// Shared definitions for the memory controller: FSM encoding, access widths,
// IO region base, LSB direction encoding and requester identities.
package riscv_defs;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_READ    = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_WAIT_IO = 2'd3;

    localparam logic [1:0] WIDTH_BYTE = 2'd1;
    localparam logic [1:0] WIDTH_HALF = 2'd2;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    localparam logic LSB_RD = 1'b1;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    // Index of the final byte of an access; 0 and 3 both mean a full word.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] width);
        logic [1:0] idx;
        case (width)
            WIDTH_BYTE: idx = 2'd0;
            WIDTH_HALF: idx = 2'd1;
            default:    idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [7:0] byte_lane(input logic [31:0] data, input logic [1:0] k);
        return data[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_controller_if.sv
// Requester-side bus of the memory controller: instruction fetch and load/store buffer.
// master = requesters, slave = controller.
interface mem_controller_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ICMC_en;
    logic [ADDR_WIDTH-1:0] ICMC_addr;
    logic                  MCIC_en;
    logic [31:0]           MCIC_data;

    logic                  LSBMC_en;
    logic                  LSBMC_wr;
    logic [1:0]            LSBMC_data_width;
    logic [31:0]           LSBMC_data;
    logic [ADDR_WIDTH-1:0] LSBMC_addr;
    logic                  MCLSB_en;
    logic [7:0]            MCLSB_data;
    logic [1:0]            MCLSB_data_number;
    logic                  MCLSB_wr_done;

    modport master (
        output ICMC_en, ICMC_addr, LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_data, LSBMC_addr,
        input  MCIC_en, MCIC_data, MCLSB_en, MCLSB_data, MCLSB_data_number, MCLSB_wr_done
    );

    modport slave (
        input  ICMC_en, ICMC_addr, LSBMC_en, LSBMC_wr, LSBMC_data_width, LSBMC_data, LSBMC_addr,
        output MCIC_en, MCIC_data, MCLSB_en, MCLSB_data, MCLSB_data_number, MCLSB_wr_done
    );
endinterface

// File: rtl/mem_controller.sv
// Purpose: arbitrates IF and LSB onto one byte-wide RAM port, one byte per cycle.
// Latency: read byte k strobes at C+k+2 (IF word at C+5); store done pulses at C+W.
// Backpressure: requests held until served; Sys_rdy=0 freezes; IO stores wait on io_buffer_full.
module mem_controller
    import riscv_defs::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] IO_BASE    = riscv_defs::IO_BASE
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst_n,
    input  logic                  Sys_rdy,
    input  logic                  RoBMC_pre_judge,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    mem_controller_if.slave       req
);

    logic [1:0]            state;
    logic [1:0]            cnt;
    logic [1:0]            last_idx;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] base_a;
    logic                  mem_wr_q;

    // Read-data pipeline: address went out last cycle, byte is on mem_din now.
    logic                  pend;
    logic                  pend_sel;
    logic [1:0]            pend_num;
    logic [23:0]           asm_q;

    logic                  drain;
    logic                  can_grant;
    logic                  grant_if;
    logic                  grant_lsb;
    logic                  lsb_io_wait;
    logic [ADDR_WIDTH-1:0] next_a;

    // No new grant until the previous transaction's strobes/done have been seen,
    // because requesters only drop their request after that pulse.
    always_comb begin
        drain       = pend | req.MCIC_en | req.MCLSB_en | req.MCLSB_wr_done;
        can_grant   = (state == ST_IDLE) & ~drain & RoBMC_pre_judge;
        grant_lsb   = can_grant & req.LSBMC_en & (~req.ICMC_en | (last_grant == GRANT_IF));
        grant_if    = can_grant & req.ICMC_en & ~grant_lsb;
        lsb_io_wait = (req.LSBMC_addr[17:16] == IO_BASE[17:16]) & io_buffer_full;
        next_a      = mem_a + ADDR_WIDTH'(1);
    end

    assign mem_wr = mem_wr_q & Sys_rdy;

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state                 <= ST_IDLE;
            cnt                   <= 2'd0;
            last_idx              <= 2'd0;
            last_grant            <= GRANT_LSB;
            base_a                <= '0;
            mem_wr_q              <= 1'b0;
            mem_a                 <= '0;
            mem_dout              <= 8'd0;
            pend                  <= 1'b0;
            pend_sel              <= GRANT_IF;
            pend_num              <= 2'd0;
            asm_q                 <= 24'd0;
            req.MCIC_en           <= 1'b0;
            req.MCIC_data         <= 32'd0;
            req.MCLSB_en          <= 1'b0;
            req.MCLSB_data        <= 8'd0;
            req.MCLSB_data_number <= 2'd0;
            req.MCLSB_wr_done     <= 1'b0;
        end else if (Sys_rdy) begin
            req.MCIC_en       <= 1'b0;
            req.MCLSB_en      <= 1'b0;
            req.MCLSB_wr_done <= 1'b0;
            pend              <= 1'b0;

            if (pend) begin
                if (pend_sel == GRANT_LSB) begin
                    req.MCLSB_en          <= 1'b1;
                    req.MCLSB_data        <= mem_din;
                    req.MCLSB_data_number <= pend_num;
                end else begin
                    case (pend_num)
                        2'd0: asm_q[7:0]   <= mem_din;
                        2'd1: asm_q[15:8]  <= mem_din;
                        2'd2: asm_q[23:16] <= mem_din;
                        default: begin
                            req.MCIC_en   <= 1'b1;
                            req.MCIC_data <= {mem_din, asm_q};
                        end
                    endcase
                end
            end

            case (state)
                ST_IDLE: begin
                    cnt <= 2'd0;
                    if (grant_lsb) begin
                        last_grant <= GRANT_LSB;
                        base_a     <= req.LSBMC_addr;
                        last_idx   <= last_byte_idx(req.LSBMC_data_width);
                        if (req.LSBMC_wr == LSB_RD) begin
                            state    <= ST_READ;
                            mem_a    <= req.LSBMC_addr;
                            mem_wr_q <= 1'b0;
                        end else if (lsb_io_wait) begin
                            state    <= ST_WAIT_IO;
                            mem_a    <= '0;
                            mem_wr_q <= 1'b0;
                        end else begin
                            state    <= ST_WRITE;
                            mem_a    <= req.LSBMC_addr;
                            mem_dout <= byte_lane(req.LSBMC_data, 2'd0);
                            mem_wr_q <= 1'b1;
                        end
                    end else if (grant_if) begin
                        last_grant <= GRANT_IF;
                        base_a     <= req.ICMC_addr;
                        last_idx   <= 2'd3;
                        state      <= ST_READ;
                        mem_a      <= req.ICMC_addr;
                        mem_wr_q   <= 1'b0;
                    end
                end
                ST_READ: begin
                    pend     <= 1'b1;
                    pend_sel <= last_grant;
                    pend_num <= cnt;
                    if (cnt == last_idx) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= cnt + 2'd1;
                        mem_a <= next_a;
                    end
                end
                ST_WRITE: begin
                    if (cnt == last_idx) begin
                        state             <= ST_IDLE;
                        mem_wr_q          <= 1'b0;
                        req.MCLSB_wr_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + 2'd1;
                        mem_a    <= next_a;
                        mem_dout <= byte_lane(req.LSBMC_data, cnt + 2'd1);
                    end
                end
                ST_WAIT_IO: begin
                    if (!io_buffer_full) begin
                        state    <= ST_WRITE;
                        mem_a    <= base_a;
                        mem_dout <= byte_lane(req.LSBMC_data, 2'd0);
                        mem_wr_q <= 1'b1;
                    end
                end
            endcase

            // Mispredict flush kills loads in flight; stores already granted are committed.
            if (!RoBMC_pre_judge) begin
                pend         <= 1'b0;
                req.MCIC_en  <= 1'b0;
                req.MCLSB_en <= 1'b0;
                if (state == ST_READ) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: backdoor-loaded RAM model, scoreboard queues for
// load strobes, fetched words and RAM writes, plus per-scenario timing checks.
module tb_mem_controller;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst_n;
    logic        Sys_rdy;
    logic        RoBMC_pre_judge;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_controller_if #(.ADDR_WIDTH(32)) bus ();

    mem_controller #(.ADDR_WIDTH(32)) dut (
        .Sys_clk         (Sys_clk),
        .Sys_rst_n       (Sys_rst_n),
        .Sys_rdy         (Sys_rdy),
        .RoBMC_pre_judge (RoBMC_pre_judge),
        .io_buffer_full  (io_buffer_full),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .mem_a           (mem_a),
        .mem_wr          (mem_wr),
        .req             (bus)
    );

    always #5 Sys_clk = ~Sys_clk;

    int cyc = 0;
    always @(posedge Sys_clk) cyc <= cyc + 1;

    // RAM model; the bench preloads through the backdoor port so one process owns the array.
    logic [7:0]  ram [0:4095];
    logic        bk_we = 1'b0;
    logic [11:0] bk_a  = 12'd0;
    logic [7:0]  bk_d  = 8'd0;
    always @(posedge Sys_clk) begin
        if (bk_we)       ram[bk_a] <= bk_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    typedef struct packed { logic [7:0] d; logic [1:0] n; } lsb_exp_t;
    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_exp_t;

    lsb_exp_t    exp_lsb [$];
    logic [31:0] exp_if  [$];
    wr_exp_t     exp_wr  [$];

    int errors = 0;
    int checks = 0;

    // Advance to just after the falling edge and retire any DUT output into the scoreboard.
    task automatic tick();
        lsb_exp_t    el;
        logic [31:0] ei;
        wr_exp_t     ew;
        @(negedge Sys_clk);
        #1;
        if (Sys_rst_n) begin
            if (bus.MCLSB_en) begin
                checks++;
                if (exp_lsb.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_strobe: unexpected byte %02h #%0d at cycle %0d", bus.MCLSB_data, bus.MCLSB_data_number, cyc);
                end else begin
                    el = exp_lsb.pop_front();
                    if ({bus.MCLSB_data, bus.MCLSB_data_number} !== el) begin
                        errors++;
                        $display("FAIL lsb_strobe: got %02h #%0d, want %02h #%0d", bus.MCLSB_data, bus.MCLSB_data_number, el.d, el.n);
                    end
                end
            end
            if (bus.MCIC_en) begin
                checks++;
                if (exp_if.size() == 0 || bus.MCLSB_en !== 1'b0) begin
                    errors++;
                    $display("FAIL if_word: unexpected word %08h (lsb_en=%b) at cycle %0d", bus.MCIC_data, bus.MCLSB_en, cyc);
                end else begin
                    ei = exp_if.pop_front();
                    if (bus.MCIC_data !== ei) begin
                        errors++;
                        $display("FAIL if_word: got %08h, want %08h", bus.MCIC_data, ei);
                    end
                end
            end
            if (mem_wr) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL ram_write: unexpected %02h @%08h at cycle %0d", mem_dout, mem_a, cyc);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({mem_a, mem_dout} !== ew) begin
                        errors++;
                        $display("FAIL ram_write: got %02h @%08h, want %02h @%08h", mem_dout, mem_a, ew.d, ew.a);
                    end
                end
            end
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        bk_a  = a;
        bk_d  = d;
        bk_we = 1'b1;
        tick();
        bk_we = 1'b0;
    endtask

    task automatic lsb_req(input logic rd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        bus.LSBMC_en         = 1'b1;
        bus.LSBMC_wr         = rd;
        bus.LSBMC_data_width = w;
        bus.LSBMC_addr       = a;
        bus.LSBMC_data       = d;
    endtask

    task automatic test_reset();
        Sys_rst_n = 1'b0;
        Sys_rdy = 1'b1; RoBMC_pre_judge = 1'b1; io_buffer_full = 1'b0;
        bus.ICMC_en = 1'b0; bus.ICMC_addr = '0;
        bus.LSBMC_en = 1'b0; bus.LSBMC_wr = 1'b0; bus.LSBMC_data_width = 2'd0;
        bus.LSBMC_data = '0; bus.LSBMC_addr = '0;
        tick(); tick();
        checks++;
        if ({mem_wr, mem_a, mem_dout} !== 41'd0) begin
            errors++;
            $display("FAIL reset_ram_port: wr=%b a=%08h dout=%02h, want all 0", mem_wr, mem_a, mem_dout);
        end
        checks++;
        if ({bus.MCIC_en, bus.MCIC_data, bus.MCLSB_en, bus.MCLSB_data, bus.MCLSB_data_number, bus.MCLSB_wr_done} !== 45'd0) begin
            errors++;
            $display("FAIL reset_req_port: ic_en=%b ic_data=%08h lsb_en=%b lsb_data=%02h", bus.MCIC_en, bus.MCIC_data, bus.MCLSB_en, bus.MCLSB_data);
        end
        Sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_fetch();
        int c0 = -1, ce = -100;
        bit bad_addr = 0;
        exp_if.push_back(32'h4433_2211);
        bus.ICMC_en = 1'b1; bus.ICMC_addr = 32'h100;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (c0 < 0 && mem_a == 32'h100) c0 = cyc;
            if (c0 >= 0 && cyc - c0 < 4 && (mem_a !== 32'h100 + 32'(cyc - c0) || mem_wr !== 1'b0)) bad_addr = 1;
            if (bus.MCIC_en) begin ce = cyc; break; end
        end
        bus.ICMC_en = 1'b0;
        checks++;
        if (bad_addr) begin errors++; $display("FAIL if_addr_seq: byte addresses not 0x100..0x103 on consecutive read cycles"); end
        checks++;
        if (ce - c0 != 5) begin errors++; $display("FAIL if_latency: MCIC_en %0d cycles after first addr, want 5", ce - c0); end
        tick();
        checks++;
        if (bus.MCIC_en !== 1'b0) begin errors++; $display("FAIL if_pulse: MCIC_en=%b one cycle later, want 0", bus.MCIC_en); end
    endtask

    task automatic test_lsb_half();
        int c0 = -1, s0 = -100, ns = 0;
        exp_lsb.push_back({8'hAA, 2'd0});
        exp_lsb.push_back({8'hBB, 2'd1});
        lsb_req(1'b1, 2'd2, 32'h200, 32'h0);
        for (int i = 0; i < 14; i++) begin
            tick();
            if (c0 < 0 && mem_a == 32'h200) c0 = cyc;
            if (bus.MCLSB_en) begin
                ns++;
                if (ns == 1) s0 = cyc;
                if (ns == 2) bus.LSBMC_en = 1'b0;
            end
        end
        bus.LSBMC_en = 1'b0;
        checks++;
        if (s0 - c0 != 2) begin errors++; $display("FAIL lh_first_strobe: %0d cycles after first addr, want 2", s0 - c0); end
        checks++;
        if (ns != 2) begin errors++; $display("FAIL lh_strobe_count: got %0d strobes, want 2", ns); end
    endtask

    task automatic test_sw();
        int c0 = -1, cd = -100;
        logic wr_at_done = 1'b1;
        exp_wr.push_back({32'h300, 8'hEF}); exp_wr.push_back({32'h301, 8'hBE});
        exp_wr.push_back({32'h302, 8'hAD}); exp_wr.push_back({32'h303, 8'hDE});
        lsb_req(1'b0, 2'd0, 32'h300, 32'hDEAD_BEEF);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c0 < 0 && mem_wr) c0 = cyc;
            if (bus.MCLSB_wr_done) begin cd = cyc; wr_at_done = mem_wr; break; end
        end
        bus.LSBMC_en = 1'b0;
        checks++;
        if (cd - c0 != 4) begin errors++; $display("FAIL sw_done_latency: done %0d cycles after first write, want 4", cd - c0); end
        checks++;
        if (wr_at_done !== 1'b0) begin errors++; $display("FAIL sw_wr_release: mem_wr=%b in done cycle, want 0", wr_at_done); end
        tick();
        checks++;
        if ({ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]} !== 32'hDEAD_BEEF || bus.MCLSB_wr_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_ram: ram=%02h%02h%02h%02h done=%b, want DEADBEEF done=0", ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300], bus.MCLSB_wr_done);
        end
    endtask

    task automatic test_arbitration();
        string order = "";
        Sys_rst_n = 1'b0; tick(); Sys_rst_n = 1'b1;
        exp_if.push_back(32'h4433_2211); exp_if.push_back(32'h4433_2211);
        exp_lsb.push_back({8'hAA, 2'd0}); exp_lsb.push_back({8'hAA, 2'd0});
        bus.ICMC_en = 1'b1; bus.ICMC_addr = 32'h100;
        lsb_req(1'b1, 2'd1, 32'h200, 32'h0);
        for (int i = 0; i < 200 && order.len() < 4; i++) begin
            tick();
            if (bus.MCIC_en)  order = {order, "I"};
            if (bus.MCLSB_en) order = {order, "L"};
        end
        bus.ICMC_en = 1'b0; bus.LSBMC_en = 1'b0;
        checks++;
        if (order != "ILIL") begin errors++; $display("FAIL arb_order: got '%s', want 'ILIL'", order); end
        repeat (4) tick();
    endtask

    task automatic test_io_wait();
        int f = -1, cw = -100, cd = -100;
        bit bad = 0;
        exp_wr.push_back({32'h3_0000, 8'h5A});
        io_buffer_full = 1'b1;
        lsb_req(1'b0, 2'd1, 32'h3_0000, 32'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_wr !== 1'b0 || (i > 0 && mem_a !== 32'h0)) bad = 1;
        end
        io_buffer_full = 1'b0;
        f = cyc;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cw < 0 && mem_wr) cw = cyc;
            if (bus.MCLSB_wr_done) begin cd = cyc; break; end
        end
        bus.LSBMC_en = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL io_hold: write activity while io_buffer_full=1"); end
        checks++;
        if (cw - f != 1) begin errors++; $display("FAIL io_release: write %0d cycles after full dropped, want 1", cw - f); end
        checks++;
        if (cd - cw != 1) begin errors++; $display("FAIL io_done: done %0d cycles after write, want 1", cd - cw); end
        tick();
    endtask

    task automatic test_flush_load();
        int ns = 0, ce = -100;
        exp_lsb.push_back({8'hAA, 2'd0}); exp_lsb.push_back({8'hBB, 2'd1});
        lsb_req(1'b1, 2'd0, 32'h200, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.MCLSB_en) ns++;
            if (ns == 2) begin RoBMC_pre_judge = 1'b0; bus.LSBMC_en = 1'b0; break; end
        end
        tick();
        RoBMC_pre_judge = 1'b1;
        if (bus.MCLSB_en) ns++;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.MCLSB_en) ns++;
        end
        checks++;
        if (ns != 2) begin errors++; $display("FAIL flush_lw_strobes: got %0d strobes, want 2", ns); end
        exp_if.push_back(32'h4433_2211);
        bus.ICMC_en = 1'b1; bus.ICMC_addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.MCIC_en) begin ce = i; break; end
        end
        bus.ICMC_en = 1'b0;
        checks++;
        if (ce < 0) begin errors++; $display("FAIL flush_recover: no IF word within 12 cycles after flush, got none, want one"); end
        tick();
    endtask

    task automatic test_flush_store();
        int c0 = -1, cd = -100;
        exp_wr.push_back({32'h300, 8'h04}); exp_wr.push_back({32'h301, 8'h03});
        exp_wr.push_back({32'h302, 8'h02}); exp_wr.push_back({32'h303, 8'h01});
        lsb_req(1'b0, 2'd3, 32'h300, 32'h0102_0304);
        for (int i = 0; i < 20; i++) begin
            tick();
            RoBMC_pre_judge = 1'b1;
            if (c0 < 0 && mem_wr) begin c0 = cyc; RoBMC_pre_judge = 1'b0; end
            if (bus.MCLSB_wr_done) begin cd = cyc; break; end
        end
        RoBMC_pre_judge = 1'b1;
        bus.LSBMC_en = 1'b0;
        checks++;
        if (cd - c0 != 4) begin errors++; $display("FAIL flush_sw_done: done %0d cycles after first write, want 4", cd - c0); end
        tick();
        checks++;
        if ({ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]} !== 32'h0102_0304) begin
            errors++;
            $display("FAIL flush_sw_ram: ram=%02h%02h%02h%02h, want 01020304", ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]);
        end
    endtask

    task automatic test_stall_write();
        int c0 = -1, cd = -100, stall = 0;
        bit bad = 0;
        exp_wr.push_back({32'h310, 8'hFE}); exp_wr.push_back({32'h311, 8'hCA});
        lsb_req(1'b0, 2'd2, 32'h310, 32'h0000_CAFE);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stall > 0) begin
                if (mem_wr !== 1'b0) bad = 1;
                stall--;
                if (stall == 0) Sys_rdy = 1'b1;
            end else if (c0 < 0 && mem_wr) begin
                c0 = cyc; Sys_rdy = 1'b0; stall = 3;
            end
            if (bus.MCLSB_wr_done) begin cd = cyc; break; end
        end
        Sys_rdy = 1'b1;
        bus.LSBMC_en = 1'b0;
        checks++;
        if (bad) begin errors++; $display("FAIL stall_wr: mem_wr=1 while Sys_rdy=0, want 0"); end
        checks++;
        if (cd - c0 != 5) begin errors++; $display("FAIL stall_done: done %0d cycles after first write, want 5", cd - c0); end
        tick();
    endtask

    task automatic test_reset_mid();
        int nw = 0, nd = 0;
        exp_wr.push_back({32'h320, 8'h44}); exp_wr.push_back({32'h321, 8'h33});
        lsb_req(1'b0, 2'd0, 32'h320, 32'h1122_3344);
        for (int i = 0; i < 20 && nw < 2; i++) begin
            tick();
            if (mem_wr) nw++;
        end
        #2;
        Sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_wr, mem_a, bus.MCLSB_wr_done} !== 34'd0) begin
            errors++;
            $display("FAIL reset_mid: wr=%b a=%08h done=%b right after reset, want all 0", mem_wr, mem_a, bus.MCLSB_wr_done);
        end
        bus.LSBMC_en = 1'b0;
        tick(); tick();
        Sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.MCLSB_wr_done) nd++;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL reset_mid_done: got %0d done pulses after reset, want 0", nd); end
    endtask

    initial begin
        test_reset();
        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h200, 8'hAA); preload(12'h201, 8'hBB);
        preload(12'h202, 8'hCC); preload(12'h203, 8'hDD);
        tick();
        test_if_fetch();
        test_lsb_half();
        test_sw();
        test_arbitration();
        test_io_wait();
        test_flush_load();
        test_flush_store();
        test_stall_write();
        test_reset_mid();
        checks++;
        if (exp_lsb.size() != 0 || exp_if.size() != 0 || exp_wr.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending lsb=%0d if=%0d wr=%0d, want 0 0 0", exp_lsb.size(), exp_if.size(), exp_wr.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
